// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass
// and a per-register busy scoreboard. Register 0 is hardwired to zero.
module regfile_mp #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_READ      = 2,
   parameter int NUM_WRITE     = 2,
   parameter int BYPASS        = 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
   output logic [NUM_READ-1:0]                rd_busy,
   input  logic [NUM_WRITE-1:0]               wr_en,
   input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data,
   input  logic                              rsv_en,
   input  logic [ADDRESS_WIDTH-1:0]           rsv_addr,
   output logic [2**ADDRESS_WIDTH-1:0]        busy_vec
);

   localparam int AW    = ADDRESS_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int DEPTH = 2**ADDRESS_WIDTH;

   if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
      $error("regfile_mp: NUM_READ must be 1..4");
   end
   if (NUM_WRITE < 1 || NUM_WRITE > 2) begin : g_bad_num_write
      $error("regfile_mp: NUM_WRITE must be 1..2");
   end
   if (BYPASS != 0 && BYPASS != 1) begin : g_bad_bypass
      $error("regfile_mp: BYPASS must be 0 or 1");
   end
   if (ADDRESS_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_width
      $error("regfile_mp: widths must be positive");
   end

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DW-1:0]    mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Next state: writes in ascending port order so the highest port wins;
   // a reservation is applied last so a new producer overrides a writeback.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      for (int j = 0; j < NUM_WRITE; j++) begin
         if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
            mem_d[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
            busy_d[wr_addr[j*AW +: AW]] = 1'b0;
         end
      end
      if (rsv_en && rsv_addr != '0) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Array and scoreboard state, cleared immediately on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         rd_data[k*DW +: DW] = mem_q[rd_addr[k*AW +: AW]];
         rd_busy[k]          = busy_q[rd_addr[k*AW +: AW]];
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WRITE; j++) begin
               if (wr_en[j] &&
                   wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW]) begin
                  rd_data[k*DW +: DW] = wr_data[j*DW +: DW];
                  rd_busy[k]          = 1'b0;
               end
            end
         end
         if (rd_addr[k*AW +: AW] == '0) begin
            rd_data[k*DW +: DW] = '0;
            rd_busy[k]          = 1'b0;
         end
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing
// instance share all inputs so both read behaviours are compared.
module tb_regfile_mp;

   logic        clock;
   logic        reset;
   logic [4:0]  ra0, ra1, wa0, wa1, rsv_addr;
   logic [31:0] wd0, wd1;
   logic        we0, we1, rsv_en;

   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;

   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_busy_a, rd_busy_b;
   logic [31:0] busy_vec_a, busy_vec_b;

   int tests = 0;
   int fails = 0;

   assign rd_addr = {ra1, ra0};
   assign wr_en   = {we1, we0};
   assign wr_addr = {wa1, wa0};
   assign wr_data = {wd1, wd0};

   regfile_mp #(.BYPASS(1)) u_byp (
      .clock(clock), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_a)
   );

   regfile_mp #(.BYPASS(0)) u_nob (
      .clock(clock), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; rsv_en = 0;
   endtask

   initial begin
      reset = 0; ra0 = 0; ra1 = 0; wa0 = 0; wa1 = 0;
      wd0 = 0; wd1 = 0; we0 = 0; we1 = 0; rsv_en = 0; rsv_addr = 0;
      #3 reset = 1;
      #1;
      check("rst_busy_a", busy_vec_a, 32'h0);
      check("rst_busy_b", busy_vec_b, 32'h0);
      for (int i = 0; i < 32; i++) begin
         ra0 = 5'(i);
         ra1 = 5'(31 - i);
         #1;
         check("rst_rd0_a", rd_data_a[31:0], 32'h0);
         check("rst_rd1_a", rd_data_a[63:32], 32'h0);
         check("rst_rd0_b", rd_data_b[31:0], 32'h0);
         check("rst_rd1_b", rd_data_b[63:32], 32'h0);
         check("rst_rdbusy", {30'b0, rd_busy_a}, 32'h0);
      end

      // writes and reservations blocked while reset is held
      we0 = 1; wa0 = 6; wd0 = 32'hFF; rsv_en = 1; rsv_addr = 6;
      step();
      idle(); ra0 = 6;
      #1;
      check("rsthold_rd", rd_data_a[31:0], 32'h0);
      check("rsthold_bv", busy_vec_a, 32'h0);
      reset = 0;
      step();

      // plain write on port0, bypass vs stored value in the write cycle
      we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra0 = 5; ra1 = 0;
      #1;
      check("wr5_byp_a", rd_data_a[31:0], 32'hDEADBEEF);
      check("wr5_old_b", rd_data_b[31:0], 32'h0);
      step();
      idle();
      #1;
      check("rd5_a", rd_data_a[31:0], 32'hDEADBEEF);
      check("rd5_b", rd_data_b[31:0], 32'hDEADBEEF);

      // writes to x0 ignored, and never forwarded
      we0 = 1; wa0 = 0; wd0 = 32'h1234; ra0 = 0; ra1 = 5;
      #1;
      check("wr0_byp_a", rd_data_a[31:0], 32'h0);
      check("rd5_p1_a", rd_data_a[63:32], 32'hDEADBEEF);
      step();
      idle();
      #1;
      check("rd0_a", rd_data_a[31:0], 32'h0);
      check("rd0_b", rd_data_b[31:0], 32'h0);

      // port1 write to x7 with read on port0
      we1 = 1; wa1 = 7; wd1 = 32'hA5A5A5A5; ra0 = 7;
      #1;
      check("wr7_byp_a", rd_data_a[31:0], 32'hA5A5A5A5);
      check("wr7_old_b", rd_data_b[31:0], 32'h0);
      step();
      idle();
      #1;
      check("rd7_b", rd_data_b[31:0], 32'hA5A5A5A5);

      // both ports hit x9: port1 wins for write and bypass
      we0 = 1; wa0 = 9; wd0 = 32'h11111111;
      we1 = 1; wa1 = 9; wd1 = 32'h22222222; ra0 = 9; ra1 = 9;
      #1;
      check("wr9_byp0_a", rd_data_a[31:0], 32'h22222222);
      check("wr9_byp1_a", rd_data_a[63:32], 32'h22222222);
      step();
      idle();
      #1;
      check("rd9_a", rd_data_a[31:0], 32'h22222222);
      check("rd9_b", rd_data_b[31:0], 32'h22222222);

      // scoreboard: reserve x3
      rsv_en = 1; rsv_addr = 3; ra0 = 3; ra1 = 0;
      #1;
      check("rsv3_pre", {30'b0, rd_busy_a}, 32'h0);
      step();
      idle();
      #1;
      check("rsv3_bv_a", busy_vec_a, 32'h8);
      check("rsv3_bv_b", busy_vec_b, 32'h8);
      check("rsv3_rdb_a", {30'b0, rd_busy_a}, 32'h1);
      check("rsv3_rdb_b", {30'b0, rd_busy_b}, 32'h1);

      // writeback to x3 clears busy
      we0 = 1; wa0 = 3; wd0 = 32'h55;
      #1;
      check("wb3_rdb_a", {30'b0, rd_busy_a}, 32'h0);
      check("wb3_rdb_b", {30'b0, rd_busy_b}, 32'h1);
      check("wb3_bv_a", busy_vec_a, 32'h8);
      step();
      idle();
      #1;
      check("wb3_bv_post", busy_vec_a, 32'h0);
      check("rd3_a", rd_data_a[31:0], 32'h55);

      // reserve and write same register: new producer wins
      we1 = 1; wa1 = 3; wd1 = 32'h66; rsv_en = 1; rsv_addr = 3;
      step();
      idle();
      #1;
      check("rsvwr3_bv", busy_vec_a, 32'h8);
      check("rsvwr3_rd", rd_data_a[31:0], 32'h66);

      // reserve x0 ignored, re-reserve x3 stays busy
      rsv_en = 1; rsv_addr = 0;
      step();
      rsv_addr = 3;
      step();
      idle();
      ra1 = 0;
      #1;
      check("rsv0_bv", busy_vec_a, 32'h8);
      check("rsv0_rdb", {31'b0, rd_busy_a[1]}, 32'h0);

      // program x4, reserve it, then pulse reset between edges
      we0 = 1; wa0 = 4; wd0 = 32'hFF;
      step();
      idle();
      rsv_en = 1; rsv_addr = 4;
      step();
      idle(); ra0 = 4;
      #1;
      check("x4_rd", rd_data_a[31:0], 32'hFF);
      check("x4_bv", busy_vec_a, 32'h18);
      reset = 1;
      #1;
      check("async_rd_a", rd_data_a[31:0], 32'h0);
      check("async_rd_b", rd_data_b[31:0], 32'h0);
      check("async_bv_a", busy_vec_a, 32'h0);
      check("async_bv_b", busy_vec_b, 32'h0);
      reset = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
